hazard_scoreboard_unit: RTL and testbench

Parametrised successor to the pipeline hazard unit.
- Keeps the combinational load-use and forwarding-limit hazard detection between ID, EX and MEM.
- Adds a register scoreboard for variable-latency write-backs, such as the multi-cycle divider and non-blocking loads.
- Adds a multi-cycle flush sequencer for exceptions/traps and a saturating stall-cycle performance counter.
- Sits beside the ID stage. Drives stall_if, stall_id, flush_id and flush_ex to the IF/ID and ID/EX pipeline registers.

---
 rtl/hazard_scoreboard_unit.sv | 153 +++++++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_unit.sv
// Hazard detection, long-latency register scoreboard, exception flush
// sequencer and saturating stall counter for the ID stage.
module hazard_scoreboard_unit #(
    parameter  int NUM_REGS     = 32,
    parameter  int NUM_SRC      = 2,
    parameter  int MAX_PENDING  = 4,
    parameter  int FLUSH_CYCLES = 2,
    parameter  int CNT_WIDTH    = 32,
    localparam int RW           = $clog2(NUM_REGS),
    localparam int PW           = $clog2(MAX_PENDING + 1)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NUM_SRC*RW-1:0]  rs_id,
    input  logic [NUM_SRC-1:0]     rs_used_id,
    input  logic                   store_id,
    input  logic [RW-1:0]          rd_ex,
    input  logic [RW-1:0]          rd_mem,
    input  logic                   reg_we_ex,
    input  logic                   reg_we_mem,
    input  logic                   mem_rd_en_ex,
    input  logic                   mem_rd_en_mem,
    input  logic                   zicsr_ex,
    input  logic                   issue_long,
    input  logic [RW-1:0]          issue_rd,
    input  logic                   complete_long,
    input  logic [RW-1:0]          complete_rd,
    input  logic                   exception,
    output logic                   stall_if,
    output logic                   stall_id,
    output logic                   flush_id,
    output logic                   flush_ex,
    output logic [NUM_REGS-1:0]    busy_regs,
    output logic [PW-1:0]          pending_count,
    output logic                   scoreboard_full,
    output logic [CNT_WIDTH-1:0]   stall_cycles
);

    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_RELOAD =
        CW'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [NUM_REGS-1:0]  busy;
    logic [NUM_REGS-1:0]  set_vec, clr_vec;
    logic [NUM_SRC-1:0]   raw;
    logic                 struct_hz, hz, flush_act;
    logic                 issue_ok, comp_ok;

    // Per-operand RAW checks; store data (operand 1) can be forwarded
    // from a load in EX, so it is exempt from the EX load-use case.
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        localparam bit IS_STORE_DATA = (k == 1);
        logic [RW-1:0] rs;
        logic          ex_hit, mem_hit;

        assign rs      = rs_id[k*RW +: RW];
        assign ex_hit  = rs_used_id[k] && rs == rd_ex &&
                         rd_ex != '0 && reg_we_ex;
        assign mem_hit = rs_used_id[k] && rs == rd_mem &&
                         rd_mem != '0 && reg_we_mem;
        assign raw[k]  = (ex_hit && (zicsr_ex ||
                         (mem_rd_en_ex && !(store_id && IS_STORE_DATA)))) ||
                         (mem_hit && mem_rd_en_mem) ||
                         (rs_used_id[k] && busy[rs]);
    end

    assign struct_hz = issue_long && (scoreboard_full || busy[issue_rd]);
    assign hz        = (|raw) || struct_hz;
    assign flush_act = exception || (state == FLUSH);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A new exception reloads the counter: flush is extended, not nested.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (exception && FLUSH_CYCLES > 1) begin
                    state_nxt = FLUSH;
                    cnt_nxt   = CNT_RELOAD;
                end
            end
            FLUSH: begin
                if (exception) begin
                    cnt_nxt = CNT_RELOAD;
                end else if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        stall_if = 1'b0;
        stall_id = 1'b0;
        flush_id = 1'b0;
        flush_ex = 1'b0;
        if (flush_act) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
        end else if (hz) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
        end
    end

    assign issue_ok = issue_long && issue_rd != '0 && !hz && !flush_act;
    assign comp_ok  = complete_long && busy[complete_rd];
    assign set_vec  = issue_ok ? (NUM_REGS'(1) << issue_rd) : '0;
    assign clr_vec  = comp_ok ? (NUM_REGS'(1) << complete_rd) : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy          <= '0;
            pending_count <= '0;
        end else begin
            busy <= (busy & ~clr_vec) | set_vec;
            unique case ({issue_ok, comp_ok})
                2'b10:   pending_count <= pending_count + 1'b1;
                2'b01:   pending_count <= pending_count - 1'b1;
                default: pending_count <= pending_count;
            endcase
        end
    end

    assign busy_regs       = busy;
    assign scoreboard_full = (pending_count == PW'(MAX_PENDING));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
        end else if (stall_id && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: vector table, directed corner
// sequences and random traffic against a queue-based model.
module tb_hazard_scoreboard_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [9:0]  rs_id;
    logic [1:0]  rs_used_id;
    logic        store_id;
    logic [4:0]  rd_ex, rd_mem, issue_rd, complete_rd;
    logic        reg_we_ex, reg_we_mem, mem_rd_en_ex, mem_rd_en_mem;
    logic        zicsr_ex, issue_long, complete_long, exception;

    logic        stall_if, stall_id, flush_id, flush_ex;
    logic [31:0] busy_regs;
    logic [2:0]  pending_count;
    logic        scoreboard_full;
    logic [31:0] stall_cycles;

    logic        s_stall_if, s_stall_id, s_flush_id, s_flush_ex;
    logic [31:0] s_busy_regs;
    logic [2:0]  s_pending_count;
    logic        s_full;
    logic [2:0]  s_stall_cycles;

    always #5 clock = ~clock;

    hazard_scoreboard_unit u_dut (
        .clock(clock), .reset_n(reset_n),
        .rs_id(rs_id), .rs_used_id(rs_used_id), .store_id(store_id),
        .rd_ex(rd_ex), .rd_mem(rd_mem),
        .reg_we_ex(reg_we_ex), .reg_we_mem(reg_we_mem),
        .mem_rd_en_ex(mem_rd_en_ex), .mem_rd_en_mem(mem_rd_en_mem),
        .zicsr_ex(zicsr_ex), .issue_long(issue_long), .issue_rd(issue_rd),
        .complete_long(complete_long), .complete_rd(complete_rd),
        .exception(exception),
        .stall_if(stall_if), .stall_id(stall_id),
        .flush_id(flush_id), .flush_ex(flush_ex),
        .busy_regs(busy_regs), .pending_count(pending_count),
        .scoreboard_full(scoreboard_full), .stall_cycles(stall_cycles)
    );

    hazard_scoreboard_unit #(.CNT_WIDTH(3)) u_sat (
        .clock(clock), .reset_n(reset_n),
        .rs_id(rs_id), .rs_used_id(rs_used_id), .store_id(store_id),
        .rd_ex(rd_ex), .rd_mem(rd_mem),
        .reg_we_ex(reg_we_ex), .reg_we_mem(reg_we_mem),
        .mem_rd_en_ex(mem_rd_en_ex), .mem_rd_en_mem(mem_rd_en_mem),
        .zicsr_ex(zicsr_ex), .issue_long(issue_long), .issue_rd(issue_rd),
        .complete_long(complete_long), .complete_rd(complete_rd),
        .exception(exception),
        .stall_if(s_stall_if), .stall_id(s_stall_id),
        .flush_id(s_flush_id), .flush_ex(s_flush_ex),
        .busy_regs(s_busy_regs), .pending_count(s_pending_count),
        .scoreboard_full(s_full), .stall_cycles(s_stall_cycles)
    );

    int     checks = 0;
    int     errors = 0;
    int     pq[$];
    int     fl_left;
    longint m_cnt, m_sat;

    typedef struct {
        logic [9:0] rs;
        logic [1:0] used;
        logic       st;
        logic [4:0] rdex;
        logic       weex, ldex, csr;
        logic [4:0] rdmem;
        logic       wemem, ldmem, exc;
        logic       e_stall, e_fid, e_fex;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic bit m_busy(int r);
        foreach (pq[i]) if (pq[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_busy_vec();
        logic [31:0] v = '0;
        foreach (pq[i]) v[pq[i]] = 1'b1;
        return v;
    endfunction

    function automatic bit m_hz();
        bit h = 1'b0;
        int rs;
        for (int k = 0; k < 2; k++) begin
            rs = (k == 0) ? int'(rs_id[4:0]) : int'(rs_id[9:5]);
            if (rs_used_id[k]) begin
                if (rs == int'(rd_ex) && rd_ex != 0 && reg_we_ex &&
                    (zicsr_ex || (mem_rd_en_ex && !(store_id && k == 1))))
                    h = 1'b1;
                if (rs == int'(rd_mem) && rd_mem != 0 && reg_we_mem &&
                    mem_rd_en_mem)
                    h = 1'b1;
                if (m_busy(rs)) h = 1'b1;
            end
        end
        if (issue_long && (pq.size() == 4 || m_busy(int'(issue_rd))))
            h = 1'b1;
        return h;
    endfunction

    task automatic clr_inputs();
        rs_id = '0; rs_used_id = '0; store_id = 0;
        rd_ex = '0; rd_mem = '0; reg_we_ex = 0; reg_we_mem = 0;
        mem_rd_en_ex = 0; mem_rd_en_mem = 0; zicsr_ex = 0;
        issue_long = 0; issue_rd = '0; complete_long = 0;
        complete_rd = '0; exception = 0;
    endtask

    // Called at a falling edge: reset is checked before any rising edge.
    task automatic do_reset();
        reset_n = 1'b0;
        clr_inputs();
        #1;
        chk("rst_busy", busy_regs, 0);
        chk("rst_pending", pending_count, 0);
        chk("rst_full", scoreboard_full, 0);
        chk("rst_stall_cycles", stall_cycles, 0);
        chk("rst_flush_id", flush_id, 0);
        chk("rst_flush_ex", flush_ex, 0);
        chk("rst_stall_id", stall_id, 0);
        pq.delete();
        fl_left = 0;
        m_cnt = 0;
        m_sat = 0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic run_cycle();
        bit hz, fa, st, iss;
        #1;
        hz = m_hz();
        fa = exception || fl_left > 0;
        st = hz && !fa;
        chk("stall_if", stall_if, st);
        chk("stall_id", stall_id, st);
        chk("flush_id", flush_id, fa);
        chk("flush_ex", flush_ex, fa || hz);
        chk("busy_regs", busy_regs, m_busy_vec());
        chk("pending_count", pending_count, pq.size());
        chk("full", scoreboard_full, pq.size() == 4);
        chk("stall_cycles", stall_cycles, m_cnt);
        chk("sat_stall_id", s_stall_id, st);
        chk("sat_flush_ex", s_flush_ex, fa || hz);
        chk("sat_stall_cycles", s_stall_cycles, m_sat);
        iss = issue_long && issue_rd != 0 && !hz && !fa;
        if (complete_long) begin
            for (int i = 0; i < pq.size(); i++) begin
                if (pq[i] == int'(complete_rd)) begin
                    pq.delete(i);
                    break;
                end
            end
        end
        if (iss) pq.push_back(int'(issue_rd));
        fl_left = exception ? 1 : (fl_left > 0 ? fl_left - 1 : 0);
        if (st) begin
            if (m_cnt != 64'hffff_ffff) m_cnt++;
            if (m_sat != 7) m_sat++;
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic set_load_use();
        rd_ex = 5; reg_we_ex = 1; mem_rd_en_ex = 1;
        rs_id = 10'h005; rs_used_id = 2'b01;
    endtask

    initial begin
        tbl[0]  = '{10'h005, 2'b01, 0, 5, 1, 1, 0, 0, 0, 0, 0, 1, 0, 1};
        tbl[1]  = '{10'h0A0, 2'b10, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{10'h005, 2'b01, 1, 5, 1, 1, 0, 0, 0, 0, 0, 1, 0, 1};
        tbl[3]  = '{10'h0A0, 2'b10, 0, 5, 1, 1, 0, 0, 0, 0, 0, 1, 0, 1};
        tbl[4]  = '{10'h000, 2'b01, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[5]  = '{10'h007, 2'b01, 0, 7, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1};
        tbl[6]  = '{10'h007, 2'b00, 0, 7, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        tbl[7]  = '{10'h0E0, 2'b10, 1, 7, 1, 0, 1, 0, 0, 0, 0, 1, 0, 1};
        tbl[8]  = '{10'h120, 2'b10, 0, 0, 0, 0, 0, 9, 1, 1, 0, 1, 0, 1};
        tbl[9]  = '{10'h120, 2'b00, 0, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0};
        tbl[10] = '{10'h120, 2'b10, 0, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0};
        tbl[11] = '{10'h005, 2'b01, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[12] = '{10'h005, 2'b01, 0, 5, 1, 1, 0, 0, 0, 0, 1, 0, 1, 1};

        clr_inputs();
        reset_n = 1'b1;
        @(negedge clock);
        do_reset();

        for (int i = 0; i < 13; i++) begin
            rs_id = tbl[i].rs; rs_used_id = tbl[i].used;
            store_id = tbl[i].st; rd_ex = tbl[i].rdex;
            reg_we_ex = tbl[i].weex; mem_rd_en_ex = tbl[i].ldex;
            zicsr_ex = tbl[i].csr; rd_mem = tbl[i].rdmem;
            reg_we_mem = tbl[i].wemem; mem_rd_en_mem = tbl[i].ldmem;
            exception = tbl[i].exc;
            #1;
            chk($sformatf("vec%0d_stall_if", i), stall_if, tbl[i].e_stall);
            chk($sformatf("vec%0d_stall_id", i), stall_id, tbl[i].e_stall);
            chk($sformatf("vec%0d_flush_id", i), flush_id, tbl[i].e_fid);
            chk($sformatf("vec%0d_flush_ex", i), flush_ex, tbl[i].e_fex);
            @(negedge clock);
        end

        // Scoreboard set, WAW stall, completion with same-cycle read
        do_reset();
        issue_long = 1; issue_rd = 3;
        run_cycle();
        issue_long = 0; rs_id = 10'h003; rs_used_id = 2'b01;
        repeat (2) run_cycle();
        chk("sb_busy_x3", busy_regs, 32'h8);
        chk("sb_pending1", pending_count, 1);
        chk("sb_stall", stall_id, 1);
        issue_long = 1; issue_rd = 3;
        run_cycle();
        chk("sb_waw_busy", busy_regs, 32'h8);
        chk("sb_waw_pending", pending_count, 1);
        issue_long = 0; complete_long = 1; complete_rd = 3;
        run_cycle();
        complete_long = 0;
        #1;
        chk("sb_cleared", busy_regs, 0);
        chk("sb_released", stall_id, 0);
        run_cycle();

        // Capacity
        do_reset();
        for (int r = 1; r <= 4; r++) begin
            issue_long = 1; issue_rd = 5'(r);
            run_cycle();
        end
        chk("cap_full", scoreboard_full, 1);
        chk("cap_pending4", pending_count, 4);
        issue_rd = 6;
        run_cycle();
        chk("cap_5th_blocked", busy_regs[6], 0);
        complete_long = 1; complete_rd = 2;
        run_cycle();
        complete_long = 0;
        chk("cap_after_complete", pending_count, 3);
        chk("cap_not_full", scoreboard_full, 0);
        run_cycle();
        chk("cap_x6_accepted", busy_regs, 32'h5A);
        chk("cap_pending_again", pending_count, 4);
        issue_long = 0; complete_long = 1; complete_rd = 9;
        run_cycle();
        complete_long = 0;
        chk("cap_ignore_complete", pending_count, 4);

        // Exception flush timing and extension
        do_reset();
        set_load_use();
        exception = 1;
        run_cycle();
        exception = 0;
        #1;
        chk("exc_flush_c1", flush_id, 1);
        chk("exc_nostall_c1", stall_id, 0);
        run_cycle();
        #1;
        chk("exc_done_c2", flush_id, 0);
        chk("exc_stall_c2", stall_id, 1);
        run_cycle();
        exception = 1;
        run_cycle();
        run_cycle();
        exception = 0;
        #1;
        chk("exc_ext_c2", flush_id, 1);
        run_cycle();
        #1;
        chk("exc_ext_done", flush_id, 0);
        run_cycle();
        clr_inputs();
        exception = 1; issue_long = 1; issue_rd = 5;
        run_cycle();
        exception = 0;
        run_cycle();
        issue_long = 0;
        chk("exc_no_issue", busy_regs, 0);
        run_cycle();

        // Stall counter and saturation
        do_reset();
        set_load_use();
        repeat (5) run_cycle();
        chk("cnt_5", stall_cycles, 5);
        repeat (5) run_cycle();
        chk("cnt_10", stall_cycles, 10);
        chk("cnt_sat7", s_stall_cycles, 7);

        // Reset mid-flush with pending ops
        do_reset();
        issue_long = 1; issue_rd = 1;
        run_cycle();
        issue_rd = 2;
        run_cycle();
        issue_long = 0; exception = 1;
        run_cycle();
        exception = 0;
        #1;
        chk("pre_rst_pending", pending_count, 2);
        chk("pre_rst_flush", flush_id, 1);
        do_reset();

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            rs_id = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            rs_used_id = 2'($urandom);
            store_id = ($urandom_range(0, 3) == 0);
            rd_ex = 5'($urandom_range(0, 7));
            rd_mem = 5'($urandom_range(0, 7));
            reg_we_ex = $urandom_range(0, 1) == 1;
            reg_we_mem = $urandom_range(0, 1) == 1;
            mem_rd_en_ex = ($urandom_range(0, 3) == 0);
            mem_rd_en_mem = ($urandom_range(0, 3) == 0);
            zicsr_ex = ($urandom_range(0, 7) == 0);
            issue_long = ($urandom_range(0, 2) == 0);
            issue_rd = 5'($urandom_range(0, 7));
            complete_long = ($urandom_range(0, 2) == 0);
            if (pq.size() > 0 && $urandom_range(0, 3) != 0)
                complete_rd = 5'(pq[$urandom_range(0, pq.size() - 1)]);
            else
                complete_rd = 5'($urandom_range(0, 7));
            exception = ($urandom_range(0, 15) == 0);
            run_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
